// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block read-only instruction cache with zero-cycle hits,
// single-word refill from the memory controller and saturating hit/miss counters.
module icache_direct #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inval,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX = $clog2(SETS);
    localparam int TAG = 30 - IDX;

    // state | meaning
    // IDLE  | serve hits, launch a refill on a miss
    // FETCH | iREN held, waiting for iwait=0 to write the latched frame
    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state;
    logic [SETS-1:0]   valid;
    logic [TAG-1:0]    tags [SETS];
    logic [31:0]       data [SETS];
    logic [29:0]       miss_addr;

    logic [TAG-1:0]    req_tag;
    logic [IDX-1:0]    req_index;
    logic [TAG-1:0]    fill_tag;
    logic [IDX-1:0]    fill_index;
    logic              fill_done;

    assign req_tag    = imemaddr[31:IDX+2];
    assign req_index  = imemaddr[IDX+1:2];
    assign fill_tag   = miss_addr[29:IDX];
    assign fill_index = miss_addr[IDX-1:0];
    assign fill_done  = (state == FETCH) && !iwait;

    assign ihit     = (state == IDLE) && imemREN && valid[req_index] && (tags[req_index] == req_tag);
    assign imemload = ihit ? data[req_index] : 32'd0;

    // Payload storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge CLK) begin
        if (!RST && fill_done) begin
            tags[fill_index] <= fill_tag;
            data[fill_index] <= iload;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_addr  <= '0;
            iREN       <= 1'b0;
            iaddr      <= 32'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (ihit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            case (state)
                IDLE: begin
                    if (imemREN && !ihit) begin
                        state     <= FETCH;
                        miss_addr <= {req_tag, req_index};
                        iREN      <= 1'b1;
                        iaddr     <= {req_tag, req_index, 2'b00};
                        if (miss_count != 32'hFFFF_FFFF)
                            miss_count <= miss_count + 32'd1;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        valid[fill_index] <= 1'b1;
                        state             <= IDLE;
                        iREN              <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so an invalidate overrides a fill landing on the same edge.
            if (inval)
                valid <= '0;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: a word-address cache model checked every cycle, plus
// directed scenarios with literal expectations (cold miss, eviction, inval, reset, saturation).
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'd0;
    logic        inval = 1'b0;
    logic        iwait = 1'b1;
    logic [31:0] iload;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    icache_direct #(.SETS(16)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .inval(inval), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2001_0005;
        return a ^ 32'hA5A5_1234;
    endfunction

    assign iload = memword(iaddr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each of 16 frames remembers the whole word address it holds.
    bit          m_fetch;
    logic [31:0] m_iaddr;
    logic [31:0] m_hits;
    logic [31:0] m_miss;
    bit          m_valid [16];
    logic [29:0] m_line  [16];
    logic [31:0] m_data  [16];
    bit          mh;

    function automatic bit m_hit();
        return !m_fetch && imemREN === 1'b1 && m_valid[imemaddr[5:2]] &&
               m_line[imemaddr[5:2]] == imemaddr[31:2];
    endfunction

    always @(posedge CLK) begin
        mh = m_hit();
        if (RST) begin
            m_fetch = 1'b0;
            m_iaddr = 32'd0;
            m_hits  = 32'd0;
            m_miss  = 32'd0;
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else begin
            if (mh && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
            if (m_fetch) begin
                if (!iwait) begin
                    m_valid[m_iaddr[5:2]] = 1'b1;
                    m_line[m_iaddr[5:2]]  = m_iaddr[31:2];
                    m_data[m_iaddr[5:2]]  = memword(m_iaddr);
                    m_fetch = 1'b0;
                end
            end else if (imemREN && !mh) begin
                m_fetch = 1'b1;
                m_iaddr = {imemaddr[31:2], 2'b00};
                if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
            end
            if (inval)
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end
        started = 1'b1;
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("cyc_ihit", {31'd0, ihit}, {31'd0, m_hit()});
            if (m_hit()) chk("cyc_imemload", imemload, m_data[imemaddr[5:2]]);
            chk("cyc_iREN", {31'd0, iREN}, {31'd0, m_fetch});
            chk("cyc_iaddr", iaddr, m_iaddr);
            chk("cyc_hit_count", hit_count, m_hits);
            chk("cyc_miss_count", miss_count, m_miss);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; imemREN = 1'b0; inval = 1'b0; iwait = 1'b1;
        step();
        step();
        RST = 1'b0;
        #2;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
    endtask

    // Starts in an IDLE cycle; returns in the cycle that serves the refilled hit.
    task automatic fill(input logic [31:0] a, input int lat);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        #2 chk("fill_first_miss", {31'd0, ihit}, 32'd0);
        step();
        for (int k = 0; k <= lat; k++) begin
            if (k == lat) iwait = 1'b0;
            #2;
            chk("fill_iREN", {31'd0, iREN}, 32'd1);
            chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
            step();
        end
        iwait = 1'b1;
        #2;
        chk("fill_hit", {31'd0, ihit}, 32'd1);
        chk("fill_data", imemload, memword(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // cold miss with 4 refill cycles
        do_reset();
        fill(32'h0000_0040, 3);
        chk("t1_imemload", imemload, 32'h2001_0005);
        chk("t1_miss_count", miss_count, 32'd1);
        step();
        #2 chk("t1_hit_count", hit_count, 32'd1);

        // conflict eviction on index 0
        fill(32'h0000_0080, 1);
        fill(32'h0000_0040, 0);
        chk("t2_miss_count", miss_count, 32'd3);

        // address change while fetching
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
        step();
        imemaddr = 32'h200;
        #2 chk("t3_iaddr_hold", iaddr, 32'h100);
        step();
        iwait = 1'b0;
        #2 chk("t3_iaddr_hold2", iaddr, 32'h100);
        step();
        iwait = 1'b1; imemaddr = 32'h100;
        #2 chk("t3_hit_100", {31'd0, ihit}, 32'd1);
        step();
        imemaddr = 32'h200;
        #2 chk("t3_miss_200", {31'd0, ihit}, 32'd0);
        step();
        #2;
        chk("t3_fetch_200", iaddr, 32'h200);
        chk("t3_miss_count", miss_count, 32'd2);
        iwait = 1'b0;
        step();
        iwait = 1'b1;
        #2 chk("t3_hit_200", {31'd0, ihit}, 32'd1);

        // inval colliding with fill completion
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b1;
        step();
        iwait = 1'b0; inval = 1'b1;
        #2 chk("t4_iREN", {31'd0, iREN}, 32'd1);
        step();
        inval = 1'b0; iwait = 1'b1;
        #2 chk("t4_no_hit", {31'd0, ihit}, 32'd0);
        step();
        #2;
        chk("t4_refetch", {31'd0, iREN}, 32'd1);
        chk("t4_miss_count", miss_count, 32'd2);
        iwait = 1'b0;
        step();
        iwait = 1'b1;
        #2 chk("t4_hit_44", {31'd0, ihit}, 32'd1);
        fill(32'h40, 0);
        fill(32'h48, 0);
        step();
        imemaddr = 32'h40;
        #2 chk("t4_warm_40", {31'd0, ihit}, 32'd1);
        step();
        imemaddr = 32'h48; inval = 1'b1;
        #2 chk("t4_hit_with_inval", {31'd0, ihit}, 32'd1);
        step();
        inval = 1'b0;
        fill(32'h40, 0);
        fill(32'h48, 0);

        // reset in the middle of a fetch
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
        step();
        step();
        RST = 1'b1;
        #2 chk("t5_in_fetch", {31'd0, iREN}, 32'd1);
        step();
        RST = 1'b0;
        #2;
        chk("t5_iREN", {31'd0, iREN}, 32'd0);
        chk("t5_ihit", {31'd0, ihit}, 32'd0);
        chk("t5_hits", hit_count, 32'd0);
        chk("t5_misses", miss_count, 32'd0);
        step();
        #2;
        chk("t5_refetch", {31'd0, iREN}, 32'd1);
        chk("t5_miss_count", miss_count, 32'd1);
        iwait = 1'b0;
        step();
        iwait = 1'b1;
        #2 chk("t5_hit", {31'd0, ihit}, 32'd1);

        // hit counter saturation
        step();
        dut.hit_count = 32'hFFFF_FFFE;
        m_hits = 32'hFFFF_FFFE;
        step();
        step();
        step();
        #2 chk("t6_saturated", hit_count, 32'hFFFF_FFFF);
        step();
        #2 chk("t6_stays", hit_count, 32'hFFFF_FFFF);
        imemREN = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block, read-only instruction cache for the pipelined MIPS core.
- Sits directly downstream of the datapath's fetch port: it serves the datapath's imemREN/imemaddr requests and returns ihit/imemload.
- On a miss it issues a single-word read to the memory controller, refills the frame, and then serves the hit.
- It also keeps saturating hit and miss counters for performance reporting.

Parameters:
SETS, 16, number of frames; power of two, at least 2. IDX = log2(SETS), TAG = 30 - IDX.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous, active-high reset
imemREN  input  1  datapath instruction read request
imemaddr  input  32  instruction byte address; bits [1:0] ignored
ihit  output  1  requested word valid this cycle
imemload  output  32  instruction word; meaningful only when ihit=1
inval  input  1  one-cycle pulse: invalidate every frame
iREN  output  1  read request to the memory controller
iaddr  output  32  word-aligned refill address
iwait  input  1  memory controller busy; iload is valid in a cycle where iREN=1 and iwait=0
iload  input  32  refill data
hit_count  output  32  saturating count of hit cycles
miss_count  output  32  saturating count of misses

Behaviour:
- Address split: tag = imemaddr[31:IDX+2], index = imemaddr[IDX+1:2].
- Each frame holds a valid bit, a TAG-bit tag and a 32-bit data word.
- Reset (RST=1 at an edge):
  - all valid bits cleared; state to IDLE; counters to 0.
  - Outputs during and after reset: ihit=0, iREN=0, iaddr=0, imemload=0 until the first hit.
  - Reset during FETCH abandons the fill: no frame is written.
- FSM states: IDLE, FETCH.
- IDLE:
  - Hit means imemREN & valid[index] & (tag == stored tag).
  - On a hit: ihit=1 combinationally in the same cycle and imemload = stored data (zero-cycle hit latency).
  - On a miss with imemREN=1: ihit=0, and on the next edge go to FETCH, latch {tag,index} into miss_addr, and increment miss_count.
  - imemREN=0: ihit=0, state stays IDLE.
- FETCH:
  - iREN=1 and iaddr = {miss_addr, 2'b00}; ihit=0.
  - When iwait=0: write iload, the tag and valid=1 into frame miss_addr.index, then return to IDLE.
  - The following cycle hits if imemaddr is unchanged, so miss penalty = memory latency + 1 cycle.
  - imemaddr changes during FETCH are ignored; the fill always completes for the latched address.
- iREN is 0 in IDLE. iaddr holds its last value in IDLE and is 0 after reset.
- inval:
  - Clears all valid bits at the next edge and does not change the FSM state.
  - inval and a fill completing in the same cycle: inval wins and the refilled frame is left invalid.
  - inval asserted in a cycle that hits in IDLE: ihit is still 1 that cycle, since the valids are cleared only at the edge.
- Counters:
  - hit_count +1 per cycle with ihit=1; miss_count +1 per IDLE-to-FETCH transition.
  - Both saturate at 32'hFFFFFFFF with no wrap.
- Conflict misses: a fill overwrites the frame unconditionally; there is no dirty state and no writeback.
- Frames are addressed only by index, so addresses that differ only in the tag evict each other.

Test Plan:
1. Cold miss then hit, iwait held 1 for 3 cycles after FETCH entry: after RST, imemREN=1, imemaddr=0x0000_0040, iload=0x2001_0005.
   - iREN=1 and iaddr=0x40 for 4 cycles.
   - Following cycle ihit=1, imemload=0x2001_0005; miss_count=1, hit_count=1.
2. Conflict eviction (SETS=16): fill 0x0000_0040, then request 0x0000_0080 (same index 0).
   - Miss, refill occurs.
   - Re-requesting 0x40 misses again; miss_count=3.
3. Address change mid-FETCH: miss on 0x100, then imemaddr switches to 0x200 while iwait=1.
   - iaddr stays 0x100 and frame index 0 is filled with tag for 0x100.
   - 0x200 (same index 0, different tag) then misses; miss_count=2.
4. Invalidate collision: inval=1 in the same cycle iwait drops for a fill of 0x44.
   - The next cycle misses again and re-enters FETCH.
   - A separate inval pulse after warm hits on 0x40 and 0x48 causes both to miss afterwards.
5. Reset mid-FETCH: assert RST while in FETCH with iwait=1.
   - Next cycle iREN=0, ihit=0, counters=0.
   - Re-requesting the address misses (no partial fill).
6. Counter saturation: force hit_count to 32'hFFFFFFFE via backdoor, then 3 consecutive hit cycles.
   - hit_count reads 32'hFFFFFFFF and stays there.
